// File: rtl/sa_ram_pkg.sv
// Shared helpers and read-pipeline state for the parametrised sa RAM.
// Imported by sa_ram_seg_merge and sa_ram_rwsp_param.
package sa_ram_pkg;

  localparam int SA_RAM_AW_MAX = 32;

  function automatic int sa_ram_aw(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int sa_ram_seg_w(input int width, input int nseg);
    return width / nseg;
  endfunction

  typedef struct packed {
    logic [SA_RAM_AW_MAX-1:0] ra_d;
    logic                     pend;
  } sa_ram_rd_t;

endpackage

// File: rtl/sa_ram_seg_merge.sv
// Per-segment merge of an old and a new word under a write mask.
// Shared by the write port and the read-during-write bypass.
module sa_ram_seg_merge
  import sa_ram_pkg::*;
#(
  parameter int WIDTH = 257,
  parameter int NSEG  = 1
) (
  input  logic [WIDTH-1:0] old_i,
  input  logic [WIDTH-1:0] new_i,
  input  logic [NSEG-1:0]  mask_i,
  output logic [WIDTH-1:0] merged_o
);

  localparam int SEG_W = sa_ram_seg_w(WIDTH, NSEG);

  for (genvar g = 0; g < NSEG; g++) begin : g_seg
    assign merged_o[g*SEG_W +: SEG_W] =
      mask_i[g] ? new_i[g*SEG_W +: SEG_W]
                : old_i[g*SEG_W +: SEG_W];
  end

endmodule

// File: rtl/sa_ram_rwsp_param.sv
// Parametrised 1R1W synchronous RAM with registered read address and data.
// Define SA_RAM_RDWR_BYPASS_EN for read-during-write bypass into dout.
module sa_ram_rwsp_param
  import sa_ram_pkg::*;
#(
  parameter  int DEPTH = 128,
  parameter  int WIDTH = 257,
  parameter  int NSEG  = 1,
  localparam int AW    = sa_ram_aw(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [AW-1:0]    ra,
  input  logic             re,
  input  logic             ore,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic [AW-1:0]    wa,
  input  logic             we,
  input  logic [NSEG-1:0]  wmask,
  input  logic [WIDTH-1:0] di,
  input  logic [31:0]      pwrbus_ram_pd
);

  localparam logic [AW:0] DEPTH_A =
    (AW+1)'(DEPTH);
  localparam logic [SA_RAM_AW_MAX-1:0] DEPTH_W =
    SA_RAM_AW_MAX'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  sa_ram_rd_t       rd_q, rd_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             vld_q;

  logic             wr_ok;
  logic [WIDTH-1:0] wr_old, wr_word;
  logic             rd_ok;
  logic [AW-1:0]    rd_idx;
  logic [WIDTH-1:0] rdata;
  logic             unused_pwr;

  assign unused_pwr = ^pwrbus_ram_pd;

  // Out-of-range write addresses are dropped.
  assign wr_ok  = we && (|wmask)
               && ({1'b0, wa} < DEPTH_A);
  assign wr_old = mem[wa];

  sa_ram_seg_merge #(
    .WIDTH (WIDTH),
    .NSEG  (NSEG)
  ) u_wr_merge (
    .old_i    (wr_old),
    .new_i    (di),
    .mask_i   (wmask),
    .merged_o (wr_word)
  );

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wa] <= wr_word;
  end

  assign rd_ok  = rd_q.ra_d < DEPTH_W;
  assign rd_idx = rd_q.ra_d[AW-1:0];
  assign rdata  = rd_ok ? mem[rd_idx] : '0;

`ifdef SA_RAM_RDWR_BYPASS_EN
  logic             byp_hit;
  logic [WIDTH-1:0] byp_word;

  assign byp_hit = we && rd_ok && (wa == rd_idx);

  sa_ram_seg_merge #(
    .WIDTH (WIDTH),
    .NSEG  (NSEG)
  ) u_byp_merge (
    .old_i    (rdata),
    .new_i    (di),
    .mask_i   (wmask),
    .merged_o (byp_word)
  );

  assign dout_d = byp_hit ? byp_word : rdata;
`else
  assign dout_d = rdata;
`endif

  // re wins over ore so back-to-back streaming keeps pend set.
  always_comb begin
    rd_d      = rd_q;
    rd_d.pend = re | (~ore & rd_q.pend);
    if (re) rd_d.ra_d = SA_RAM_AW_MAX'(ra);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_q   <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      rd_q <= rd_d;
      if (ore) begin
        dout_q <= dout_d;
        vld_q  <= rd_q.pend;
      end
    end
  end

  assign dout     = dout_q;
  assign dout_vld = vld_q;

endmodule

// File: tb/tb_sa_ram_rwsp_param.sv
// Bench for sa_ram_rwsp_param: two configurations checked against a
// behavioural model every cycle, plus hand-computed directed expectations.
module tb_sa_ram_rwsp_param;

`ifdef SA_RAM_RDWR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [6:0]   ra [2];
  logic [6:0]   wa [2];
  logic         re [2];
  logic         ore [2];
  logic         we [2];
  logic [3:0]   wm [2];
  logic [256:0] di [2];

  logic [256:0] dout_a;
  logic [31:0]  dout_b;
  logic         vld_a, vld_b;

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 1'b0;

  sa_ram_rwsp_param #(.DEPTH(128), .WIDTH(257), .NSEG(1)) u_a (
    .clk           (clk),
    .rstn          (rstn),
    .ra            (ra[0]),
    .re            (re[0]),
    .ore           (ore[0]),
    .dout          (dout_a),
    .dout_vld      (vld_a),
    .wa            (wa[0]),
    .we            (we[0]),
    .wmask         (wm[0][0:0]),
    .di            (di[0]),
    .pwrbus_ram_pd (32'h0)
  );

  sa_ram_rwsp_param #(.DEPTH(100), .WIDTH(32), .NSEG(4)) u_b (
    .clk           (clk),
    .rstn          (rstn),
    .ra            (ra[1]),
    .re            (re[1]),
    .ore           (ore[1]),
    .dout          (dout_b),
    .dout_vld      (vld_b),
    .wa            (wa[1]),
    .we            (we[1]),
    .wmask         (wm[1]),
    .di            (di[1][31:0]),
    .pwrbus_ram_pd (32'hdead_0001)
  );

  // ---------------- behavioural model ----------------
  logic [256:0] mm [2][128];
  int           m_addr [2];
  bit           m_pend [2];
  logic [256:0] m_dout [2];
  bit           m_vld [2];

  function automatic int dep(input int i);
    return (i == 0) ? 128 : 100;
  endfunction
  function automatic int segw(input int i);
    return (i == 0) ? 257 : 8;
  endfunction
  function automatic int nseg(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  // What dout would capture this cycle if ore fires.
  function automatic logic [256:0] rdval(input int i);
    logic [256:0] v;
    v = (m_addr[i] < dep(i)) ? mm[i][m_addr[i]] : '0;
    if (BYP && we[i] && int'(wa[i]) == m_addr[i]
        && m_addr[i] < dep(i)) begin
      for (int b = 0; b < 257; b++)
        if (b / segw(i) < nseg(i) && wm[i][b / segw(i)])
          v[b] = di[i][b];
    end
    return v;
  endfunction

  initial begin
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 128; k++) mm[i][k] = '0;
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        m_addr[i] <= 0;
        m_pend[i] <= 1'b0;
        m_dout[i] <= '0;
        m_vld[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (ore[i]) begin
          m_dout[i] <= rdval(i);
          m_vld[i]  <= m_pend[i];
        end
        if (re[i])       m_pend[i] <= 1'b1;
        else if (ore[i]) m_pend[i] <= 1'b0;
        if (re[i]) m_addr[i] <= int'(ra[i]);
        if (we[i] && int'(wa[i]) < dep(i))
          for (int b = 0; b < 257; b++)
            if (b / segw(i) < nseg(i) && wm[i][b / segw(i)])
              mm[i][wa[i]][b] <= di[i][b];
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [256:0] act,
                     input logic [256:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started && rstn) begin
      chk("model_a_dout", dout_a, m_dout[0]);
      chk("model_a_vld", 257'(vld_a), 257'(m_vld[0]));
      chk("model_b_dout", 257'(dout_b), m_dout[1]);
      chk("model_b_vld", 257'(vld_b), 257'(m_vld[1]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      re[i] = 1'b0; ore[i] = 1'b0; we[i] = 1'b0;
      ra[i] = '0;   wa[i]  = '0;   wm[i] = '0;
      di[i] = '0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    idle();
  endtask

  task automatic wr(input int i, input int a, input logic [256:0] d,
                    input logic [3:0] m);
    we[i] = 1'b1; wa[i] = 7'(a); di[i] = d; wm[i] = m;
  endtask

  task automatic rd(input int i, input int a);
    re[i] = 1'b1; ra[i] = 7'(a);
    tick();
    ore[i] = 1'b1;
    tick();
  endtask

  logic [256:0] pat;

  initial begin
    idle();
    pat  = {1'b1, {31{8'h5a}}, 8'hab};
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_dout", dout_a, 257'h0);
    chk("reset_vld", 257'(vld_a), 257'h0);
    rstn    = 1'b1;
    started = 1'b1;

    for (int k = 0; k < 128; k++) begin
      wr(0, k, 257'(k), 4'h1);
      if (k < 100) wr(1, k, 257'({4{8'(k)}}), 4'hf);
      tick();
    end

    // Single word write/read at 2-cycle latency.
    wr(0, 5, pat, 4'h1);
    tick();
    re[0] = 1'b1; ra[0] = 7'd5;
    tick();
    chk("t1_vld_before_ore", 257'(vld_a), 257'h0);
    ore[0] = 1'b1;
    tick();
    chk("t1_dout", dout_a, pat);
    chk("t1_vld", 257'(vld_a), 257'h1);
    wr(0, 5, 257'd5, 4'h1);
    tick();

    // Streaming: re on cycle j, ore on cycle j+1.
    for (int j = 0; j <= 128; j++) begin
      if (j < 128) begin re[0] = 1'b1; ra[0] = 7'(j); end
      if (j >= 1) ore[0] = 1'b1;
      tick();
      if (j >= 1) begin
        chk("t2_stream_dout", dout_a, 257'(j - 1));
        chk("t2_stream_vld", 257'(vld_a), 257'h1);
      end
    end
    ore[0] = 1'b1;
    tick();
    chk("t2_ore_only_dout", dout_a, 257'd127);
    chk("t2_ore_only_vld", 257'(vld_a), 257'h0);

    // Segment masks on the 4-segment instance.
    wr(1, 3, 257'h0AAAAAAAA, 4'hf);
    tick();
    wr(1, 3, 257'h055555555, 4'b0101);
    tick();
    rd(1, 3);
    chk("t3_mask_merge", 257'(dout_b), 257'h0AA55AA55);
    wr(1, 3, 257'h0, 4'b0000);
    tick();
    rd(1, 3);
    chk("t3_zero_mask_noop", 257'(dout_b), 257'h0AA55AA55);

    // Read-during-write collision, full mask.
    wr(0, 7, 257'h0, 4'h1);
    tick();
    re[0] = 1'b1; ra[0] = 7'd7;
    tick();
    ore[0] = 1'b1;
    wr(0, 7, 257'hff, 4'h1);
    tick();
    chk("t4_collide_dout", dout_a, BYP ? 257'hff : 257'h0);
    chk("t4_collide_vld", 257'(vld_a), 257'h1);
    rd(0, 7);
    chk("t4_after_write", dout_a, 257'hff);

    // Read-during-write collision, partial mask.
    re[1] = 1'b1; ra[1] = 7'd3;
    tick();
    ore[1] = 1'b1;
    wr(1, 3, 257'h011223344, 4'b0011);
    tick();
    chk("t4_collide_part", 257'(dout_b),
        BYP ? 257'h0AA553344 : 257'h0AA55AA55);
    rd(1, 3);
    chk("t4_part_after", 257'(dout_b), 257'h0AA553344);

    // Out-of-range addresses on the DEPTH=100 instance.
    wr(1, 120, 257'h0DEADBEEF, 4'hf);
    tick();
    rd(1, 120);
    chk("t5_oob_read", 257'(dout_b), 257'h0);
    chk("t5_oob_vld", 257'(vld_b), 257'h1);
    rd(1, 99);
    chk("t5_last_word", 257'(dout_b), 257'h063636363);
    rd(1, 20);
    chk("t5_word20", 257'(dout_b), 257'h014141414);

    // Reset between re and ore drops the pending read.
    re[1] = 1'b1; ra[1] = 7'd3;
    tick();
    rstn = 1'b0;
    #1;
    chk("t5_rst_vld", 257'(vld_b), 257'h0);
    chk("t5_rst_dout", 257'(dout_b), 257'h0);
    tick();
    rstn = 1'b1;
    ore[1] = 1'b1;
    tick();
    chk("t5_post_rst_vld", 257'(vld_b), 257'h0);
    chk("t5_post_rst_dout", 257'(dout_b), 257'h0);
    rd(1, 3);
    chk("t5_array_kept", 257'(dout_b), 257'h0AA553344);
    chk("t5_array_kept_vld", 257'(vld_b), 257'h1);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
